// File: rtl/move_cmd_scheduler_pkg.sv
// Shared definitions for the drive command path: move codes,
// the encoding of which source owns the drive, and the frame
// sequencer states.
package drive_pkg;

    localparam logic [3:0] MV_FWD      = 4'b0000;
    localparam logic [3:0] MV_LEFT     = 4'b0001;
    localparam logic [3:0] MV_RIGHT    = 4'b0010;
    localparam logic [3:0] MV_REV      = 4'b0011;
    localparam logic [3:0] MV_SPIN_CCW = 4'b0100;
    localparam logic [3:0] MV_SPIN_CW  = 4'b0101;
    localparam logic [3:0] MV_REV_L    = 4'b0110;
    localparam logic [3:0] MV_REV_R    = 4'b0111;
    localparam logic [3:0] MV_STOP     = 4'b1000;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_MAN  = 2'b01,
        OWN_AUTO = 2'b10
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_SEND = 2'b10
    } tx_state_t;

endpackage

// File: rtl/move_cmd_scheduler_if.sv
// Valid/ready frame link between the scheduler and the motor-link
// UART transmitter. The scheduler is the master and offers frames.
interface move_cmd_scheduler_if #(
    parameter int CMD_W = 4,
    parameter int SPD_W = 4
) ();

    logic             tx_valid;
    logic             tx_ready;
    logic [CMD_W-1:0] tx_move_cmd;
    logic [SPD_W-1:0] tx_speed;

    modport master (
        output tx_valid,
        output tx_move_cmd,
        output tx_speed,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_move_cmd,
        input  tx_speed,
        output tx_ready
    );

endinterface

// File: rtl/move_cmd_scheduler_timer.sv
// Saturating cycle counter. Counts while run is high, restarts from
// zero on clear, and parks at LIMIT-1 where expired stays asserted
// until the next clear.
module cycle_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int         W    = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    // Count up while running, stopping at the terminal value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != LAST)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/move_cmd_scheduler.sv
// Arbitrates drive ownership between the manual and autonomous
// decoders, tracks the command currently in force, and sequences
// {move_cmd, speed} frames onto the motor-link transmitter. A STOP is
// forced after reset, on any ownership change and when the owning
// source goes silent for too long; unchanged commands are re-sent
// periodically so the motor side never acts on a stale frame.
module move_cmd_scheduler
    import drive_pkg::*;
#(
    parameter int WDOG_CYCLES    = 25_000_000,
    parameter int REFRESH_CYCLES = 5_000_000,
    parameter int CMD_W          = 4,
    parameter int SPD_W          = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 manual_on,
    input  logic                 auto_on,
    input  logic                 man_valid,
    input  logic [CMD_W-1:0]     man_cmd,
    input  logic [SPD_W-1:0]     man_speed,
    input  logic                 auto_valid,
    input  logic [CMD_W-1:0]     auto_cmd,
    input  logic [SPD_W-1:0]     auto_speed,
    move_cmd_scheduler_if.master tx,
    output logic [1:0]           owner,
    output logic                 wdog_trip
);

    localparam logic [CMD_W-1:0] STOP_CODE = CMD_W'(MV_STOP);

    owner_t           owner_q;
    owner_t           owner_new;
    logic             owner_chg;
    logic             accept;
    logic [CMD_W-1:0] strobe_cmd;
    logic [SPD_W-1:0] strobe_spd;

    logic [CMD_W-1:0] cur_cmd;
    logic [SPD_W-1:0] cur_spd;
    logic [CMD_W-1:0] last_cmd;
    logic [SPD_W-1:0] last_spd;
    logic             sent_valid;

    logic             wdog_clear;
    logic             wdog_run;
    logic             wdog_expired;
    logic             refresh_clear;
    logic             refresh_run;
    logic             refresh_expired;

    tx_state_t        state_q;
    tx_state_t        state_d;

    // Decide who owns the drive this cycle and whether the owner's strobe is taken;
    // a strobe landing in the same cycle as an ownership change is deliberately lost.
    always_comb begin
        owner_new  = OWN_NONE;
        accept     = 1'b0;
        strobe_cmd = man_cmd;
        strobe_spd = man_speed;
        if (manual_on) begin
            owner_new = OWN_MAN;
        end else if (auto_on) begin
            owner_new = OWN_AUTO;
        end
        owner_chg = (owner_new != owner_q);
        if (!owner_chg) begin
            if (owner_q == OWN_MAN) begin
                accept = man_valid;
            end else if (owner_q == OWN_AUTO) begin
                accept     = auto_valid;
                strobe_cmd = auto_cmd;
                strobe_spd = auto_speed;
            end
        end
    end

    // Command in force: ownership changes and watchdog expiry force STOP, illegal codes collapse to STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= OWN_NONE;
            cur_cmd   <= STOP_CODE;
            cur_spd   <= '0;
            wdog_trip <= 1'b0;
        end else begin
            owner_q <= owner_new;
            if (owner_chg) begin
                cur_cmd   <= STOP_CODE;
                cur_spd   <= '0;
                wdog_trip <= 1'b0;
            end else if (accept) begin
                if (strobe_cmd >= STOP_CODE) begin
                    cur_cmd <= STOP_CODE;
                    cur_spd <= '0;
                end else begin
                    cur_cmd <= strobe_cmd;
                    cur_spd <= strobe_spd;
                end
                wdog_trip <= 1'b0;
            end else if (wdog_expired && wdog_run) begin
                cur_cmd   <= STOP_CODE;
                cur_spd   <= '0;
                wdog_trip <= 1'b1;
            end
        end
    end

    assign owner      = owner_q;
    assign wdog_clear = owner_chg || accept;
    assign wdog_run   = (owner_q != OWN_NONE) && !wdog_trip;

    cycle_timer #(.LIMIT(WDOG_CYCLES)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wdog_clear),
        .run     (wdog_run),
        .expired (wdog_expired)
    );

    assign refresh_clear = (state_q == ST_SEND) && tx.tx_ready;
    assign refresh_run   = (state_q == ST_IDLE) && sent_valid;

    cycle_timer #(.LIMIT(REFRESH_CYCLES)) u_refresh (
        .clk     (clk),
        .rst     (rst),
        .clear   (refresh_clear),
        .run     (refresh_run),
        .expired (refresh_expired)
    );

    // Frame sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start a frame when nothing has gone out yet, the command differs from the last one sent, or a refresh is due.
    always_comb begin
        state_d     = state_q;
        tx.tx_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!sent_valid || (cur_cmd != last_cmd) || (cur_spd != last_spd) || refresh_expired) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                tx.tx_valid = 1'b1;
                if (tx.tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Snapshot the payload in LOAD so later commands cannot disturb a frame in flight; remember what was delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx.tx_move_cmd <= STOP_CODE;
            tx.tx_speed    <= '0;
            last_cmd       <= STOP_CODE;
            last_spd       <= '0;
            sent_valid     <= 1'b0;
        end else begin
            if (state_q == ST_LOAD) begin
                tx.tx_move_cmd <= cur_cmd;
                tx.tx_speed    <= cur_spd;
            end
            if ((state_q == ST_SEND) && tx.tx_ready) begin
                last_cmd   <= tx.tx_move_cmd;
                last_spd   <= tx.tx_speed;
                sent_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_move_cmd_scheduler.sv
// Randomised scoreboard bench for move_cmd_scheduler. Stimulus tasks
// push the frames the drive rules call for; a negedge monitor pops and
// compares every completed transfer, and treats a repeat of the last
// delivered frame as a periodic refresh whose spacing it checks.
module tb_move_cmd_scheduler;

    localparam int WDOG    = 100;
    localparam int REFRESH = 50;
    localparam logic [7:0] STOP_FRAME = 8'h80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       manual_on = 1'b0;
    logic       auto_on = 1'b0;
    logic       man_valid = 1'b0;
    logic [3:0] man_cmd = 4'd0;
    logic [3:0] man_speed = 4'd0;
    logic       auto_valid = 1'b0;
    logic [3:0] auto_cmd = 4'd0;
    logic [3:0] auto_speed = 4'd0;
    logic [1:0] owner;
    logic       wdog_trip;

    move_cmd_scheduler_if #(.CMD_W(4), .SPD_W(4)) bus ();

    move_cmd_scheduler #(
        .WDOG_CYCLES    (WDOG),
        .REFRESH_CYCLES (REFRESH),
        .CMD_W          (4),
        .SPD_W          (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .manual_on  (manual_on),
        .auto_on    (auto_on),
        .man_valid  (man_valid),
        .man_cmd    (man_cmd),
        .man_speed  (man_speed),
        .auto_valid (auto_valid),
        .auto_cmd   (auto_cmd),
        .auto_speed (auto_speed),
        .tx         (bus),
        .owner      (owner),
        .wdog_trip  (wdog_trip)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_exp = STOP_FRAME;
    int         bench_owner = 0;
    bit         coalesce = 1'b0;
    logic [7:0] pending = STOP_FRAME;

    logic [7:0] mon_last = 8'h00;
    bit         mon_have = 1'b0;
    int         mon_last_cyc = 0;
    bit         stall = 1'b0;
    int         n_refresh = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Frame the motor side should receive for a command: codes above STOP become STOP, STOP carries speed 0.
    function automatic logic [7:0] sanitize(input logic [3:0] c, input logic [3:0] s);
        if (c >= 4'd8) return STOP_FRAME;
        return {c, s};
    endfunction

    task automatic expect_frame(input logic [7:0] f);
        if (f != last_exp) begin
            exp_q.push_back(f);
            last_exp = f;
        end
    endtask

    task automatic applyStimulus(input int src, input logic [3:0] c, input logic [3:0] s);
        @(posedge clk); #1;
        if (src == 1) begin
            man_valid = 1'b1; man_cmd = c; man_speed = s;
        end else begin
            auto_valid = 1'b1; auto_cmd = c; auto_speed = s;
        end
        if (src == bench_owner) begin
            if (coalesce) pending = sanitize(c, s);
            else          expect_frame(sanitize(c, s));
        end
        @(posedge clk); #1;
        man_valid = 1'b0;
        auto_valid = 1'b0;
    endtask

    task automatic set_mode(input logic m, input logic a, input logic strobe_auto,
                            input logic [3:0] c, input logic [3:0] s);
        int new_owner;
        @(posedge clk); #1;
        manual_on = m;
        auto_on = a;
        if (strobe_auto) begin
            auto_valid = 1'b1; auto_cmd = c; auto_speed = s;
        end
        new_owner = m ? 1 : (a ? 2 : 0);
        if (new_owner != bench_owner) expect_frame(STOP_FRAME);
        bench_owner = new_owner;
        @(posedge clk); #1;
        auto_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput(name, exp_q.size(), 0);
    endtask

    task automatic fresh_frame();
        logic [3:0] c;
        logic [3:0] s;
        do begin
            c = 4'($urandom_range(0, 7));
            s = 4'($urandom_range(0, 15));
        end while (sanitize(c, s) == last_exp);
        applyStimulus(1, c, s);
        wait_drain(8, "fresh_frame_drain");
    endtask

    // Scoreboard monitor: every completed transfer is either the next expected frame or a timed refresh.
    always @(negedge clk) begin
        logic [7:0] frame;
        if (rst) begin
            mon_have = 1'b0;
            stall = 1'b0;
        end else if (bus.tx_valid) begin
            if (!bus.tx_ready) begin
                stall = 1'b1;
            end else begin
                frame = {bus.tx_move_cmd, bus.tx_speed};
                if (mon_have && frame == mon_last) begin
                    n_refresh++;
                    if (!stall) checkOutput("refresh_interval", cyc - mon_last_cyc, REFRESH + 2);
                    else        checkOutput("refresh_min_interval", 32'(cyc - mon_last_cyc >= REFRESH + 2), 1);
                end else if (exp_q.size() == 0) begin
                    n_total++;
                    $display("[TB] FAIL unexpected_frame: got 0x%0h, expected no frame", frame);
                end else begin
                    checkOutput("frame", frame, exp_q.pop_front());
                end
                mon_last = frame;
                mon_have = 1'b1;
                mon_last_cyc = cyc;
                stall = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        logic [3:0] ca;
        logic [3:0] sa;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [7:0] frame_a;
        bit         changed;
        bit         seen;
        int         k;
        int         ref0;
        int         src;

        bus.tx_ready = 1'b1;
        $display("[TB] reset checks");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_tx_valid", bus.tx_valid, 0);
        checkOutput("reset_tx_move_cmd", bus.tx_move_cmd, 4'b1000);
        checkOutput("reset_tx_speed", bus.tx_speed, 0);
        checkOutput("reset_owner", owner, 0);
        checkOutput("reset_wdog_trip", wdog_trip, 0);

        exp_q.delete();
        exp_q.push_back(STOP_FRAME);
        last_exp = STOP_FRAME;
        rst = 1'b0;
        wait_drain(4, "reset_stop_frame");
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.tx_valid) seen = 1'b1;
        end
        checkOutput("idle_after_reset_frame", seen, 0);

        $display("[TB] manual ownership and latency");
        set_mode(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("owner_manual", owner, 2'b01);
        applyStimulus(1, 4'b0000, 4'd3);
        k = 0;
        while (!bus.tx_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("strobe_to_valid_latency", k, 2);
        wait_drain(6, "first_manual_frame");

        $display("[TB] random manual traffic");
        for (int i = 0; i < 25; i++) begin
            src = ($urandom_range(0, 3) == 0) ? 2 : 1;
            applyStimulus(src, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(8, 12)) @(posedge clk);
        end
        wait_drain(10, "random_manual_drain");

        $display("[TB] backpressure");
        fresh_frame();
        bus.tx_ready = 1'b0;
        do begin
            ca = 4'($urandom_range(3, 7));
            sa = 4'($urandom_range(0, 15));
        end while (sanitize(ca, sa) == last_exp);
        frame_a = sanitize(ca, sa);
        applyStimulus(1, ca, sa);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_tx_valid", bus.tx_valid, 1);
        checkOutput("bp_payload", {bus.tx_move_cmd, bus.tx_speed}, frame_a);
        coalesce = 1'b1;
        changed = 1'b0;
        s1 = 4'($urandom_range(0, 15));
        s2 = 4'($urandom_range(0, 15));
        for (int i = 0; i < 20; i++) begin
            if (i == 2)      applyStimulus(1, 4'b0001, s1);
            else if (i == 8) applyStimulus(1, 4'b0010, s2);
            else begin
                @(posedge clk); #1;
            end
            if (!bus.tx_valid || {bus.tx_move_cmd, bus.tx_speed} != frame_a) changed = 1'b1;
        end
        checkOutput("bp_payload_held", changed, 0);
        coalesce = 1'b0;
        expect_frame(pending);
        bus.tx_ready = 1'b1;
        wait_drain(10, "bp_release_drain");

        $display("[TB] illegal code");
        applyStimulus(1, 4'b0101, 4'd9);
        wait_drain(8, "code_0101_drain");
        applyStimulus(1, 4'b1110, 4'd5);
        wait_drain(8, "code_1110_as_stop");

        $display("[TB] watchdog");
        applyStimulus(1, 4'b0000, 4'd2);
        expect_frame(STOP_FRAME);
        k = 0;
        while (!wdog_trip && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("wdog_trip_timing", 32'(k >= WDOG - 1 && k <= WDOG + 1), 1);
        wait_drain(8, "wdog_stop_frame");
        repeat (20) @(posedge clk);
        #1;
        checkOutput("wdog_trip_held", wdog_trip, 1);
        applyStimulus(1, 4'b0011, 4'd4);
        checkOutput("wdog_trip_cleared", wdog_trip, 0);
        wait_drain(8, "after_wdog_frame");

        $display("[TB] owner change to auto");
        set_mode(1'b0, 1'b1, 1'b1, 4'b0011, 4'd6);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("owner_auto", owner, 2'b10);
        wait_drain(8, "owner_change_stop");
        applyStimulus(2, 4'b0011, 4'd6);
        wait_drain(8, "auto_0011_frame");
        for (int i = 0; i < 10; i++) begin
            src = ($urandom_range(0, 3) == 0) ? 1 : 2;
            applyStimulus(src, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(8, 12)) @(posedge clk);
        end
        wait_drain(10, "random_auto_drain");

        $display("[TB] no owner");
        set_mode(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        wait_drain(8, "owner_none_stop");
        ref0 = n_refresh;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(($urandom_range(0, 1) == 0) ? 1 : 2,
                          4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            repeat (8) @(posedge clk);
        end
        #1;
        checkOutput("owner_none", owner, 2'b00);
        checkOutput("no_wdog_without_owner", wdog_trip, 0);
        checkOutput("refresh_frames_seen", 32'(n_refresh - ref0 >= 2), 1);

        $display("[TB] reset during send");
        set_mode(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        fresh_frame();
        bus.tx_ready = 1'b0;
        applyStimulus(1, 4'b0110, 4'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_reset_tx_valid", bus.tx_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_tx_valid", bus.tx_valid, 0);
        exp_q.delete();
        exp_q.push_back(STOP_FRAME);
        last_exp = STOP_FRAME;
        repeat (2) @(posedge clk);
        #1;
        bus.tx_ready = 1'b1;
        rst = 1'b0;
        wait_drain(6, "post_reset_stop");
        checkOutput("owner_after_reset", owner, 2'b01);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
